alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 26 ++
 rtl/cmd_fifo.sv | 63 ++++++
 rtl/alu_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared types and widths for the ALU command sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_sequencer_pkg;

    localparam int OPND_W   = 8;                 // each ALU operand
    localparam int ALU_IN_W = 2 * OPND_W;        // packed {a, b} toward the ALU
    localparam int OP_W     = 2;                 // ALU opcode
    localparam int ENTRY_W  = OP_W + 2 * OPND_W; // one queued command (18 bits)

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE,
        ST_RESP
    } state_e;

    // Field order matches the FIFO entry layout {op, a, b}.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
    } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Command queue: power-of-two depth FIFO with full/empty flags.
// Latency: an entry pushed on one edge is visible at rdata_o after that edge; no bypass.
// Backpressure: push ignored while full (even with a same-cycle pop); pop ignored while empty.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    // Flags come from the registered count, so a pop never frees space for a same-cycle push.
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage array: written only on an accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Queues {op,a,b} commands and runs them one at a time through an external ALU.
// Latency: pop -> ISSUE(1) + WAIT(>=1, timeout bound) + CAPTURE(1) -> rsp_valid; one IDLE between ops.
// Backpressure: cmd_ready drops when the queue is full; RESP holds until rsp_ready.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [OPND_W-1:0]   cmd_a,
    input  logic [OPND_W-1:0]   cmd_b,
    input  logic [OP_W-1:0]     cmd_op,
    output logic [ALU_IN_W-1:0] alu_in,
    output logic [OP_W-1:0]     alu_op,
    output logic                alu_valid,
    input  logic                alu_ready,
    input  logic [OPND_W-1:0]   alu_result,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [OPND_W-1:0]   rsp_data,
    output logic [OP_W-1:0]     rsp_op,
    output logic                rsp_err,
    output logic                busy,
    output logic [7:0]          timeout_cnt
);

    localparam int                WCNT_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WCNT_W-1:0] TIMEOUT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

    state_e              state_q;
    cmd_t                opnd_q;
    cmd_t                fifo_wdata;
    cmd_t                fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic                ready_en_q;
    logic                alu_rdy_prev_q;
    logic                alu_done;
    logic                alu_valid_q;
    logic                rsp_valid_q;
    logic [OPND_W-1:0]   rsp_data_q;
    logic [OP_W-1:0]     rsp_op_q;
    logic                rsp_err_q;
    logic [WCNT_W-1:0]   wait_cnt_q;
    logic [7:0]          timeout_cnt_q;

    // ready_en_q keeps cmd_ready low during reset and until the first clock after release.
    assign cmd_ready  = ready_en_q && !fifo_full;
    assign fifo_push  = cmd_valid && cmd_ready;
    assign fifo_wdata = '{op: cmd_op, a: cmd_a, b: cmd_b};
    assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;

    // Only a fresh 0->1 transition counts, so a ready level left over from the last op is ignored.
    assign alu_done = alu_ready && !alu_rdy_prev_q;

    // The operand register drives the ALU directly, so alu_in/alu_op stay put for the whole op.
    assign alu_in      = {opnd_q.a, opnd_q.b};
    assign alu_op      = opnd_q.op;
    assign alu_valid   = alu_valid_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_op      = rsp_op_q;
    assign rsp_err     = rsp_err_q;
    assign timeout_cnt = timeout_cnt_q;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Sequencer FSM with registered ALU/response outputs, wait timer and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            opnd_q         <= '0;
            ready_en_q     <= 1'b0;
            alu_rdy_prev_q <= 1'b0;
            alu_valid_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            rsp_op_q       <= '0;
            rsp_err_q      <= 1'b0;
            wait_cnt_q     <= '0;
            timeout_cnt_q  <= '0;
        end else begin
            ready_en_q     <= 1'b1;
            alu_rdy_prev_q <= alu_ready;
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        opnd_q      <= fifo_rdata;
                        alu_valid_q <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    alu_valid_q <= 1'b0;
                    wait_cnt_q  <= '0;
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (alu_done) begin
                        state_q <= ST_CAPTURE;
                    end else if (wait_cnt_q == TIMEOUT_LAST) begin
                        // ALU never answered: report an error response carrying no data.
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_op_q    <= opnd_q.op;
                        rsp_err_q   <= 1'b1;
                        if (timeout_cnt_q != 8'hFF) begin
                            timeout_cnt_q <= timeout_cnt_q + 1'b1;
                        end
                        state_q <= ST_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    // The ALU result register has updated by now; take it on the way out.
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= alu_result;
                    rsp_op_q    <= opnd_q.op;
                    rsp_err_q   <= 1'b0;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    alu_valid_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
